// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction fetch controller
// and the instruction-memory wrapper.
package imem_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] PC_INC     = 32'd4;
    localparam int unsigned ADDR_SHIFT = 2;
    localparam int unsigned IMEM_DEPTH = 1024;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Synchronous-read instruction BRAM port: the controller drives address and
// enable, the memory returns the word one cycle after an enabled read.
interface imem_fetch_ctrl_if;

    logic [31:0] imem_addr;
    logic        imem_ena;
    logic [31:0] imem_instr;

    modport master (output imem_addr, output imem_ena, input imem_instr);
    modport slave  (input imem_addr, input imem_ena, output imem_instr);

endinterface

// File: rtl/pc_range_check.sv
// Flags a byte PC that is not word aligned or lies beyond the instruction memory.
module pc_range_check
    import imem_pkg::*;
(
    input  logic [31:0] pc,
    output logic        bad
);

    logic misaligned;
    logic out_of_range;

    always_comb begin
        misaligned   = |pc[ADDR_SHIFT-1:0];
        out_of_range = (pc >> ADDR_SHIFT) >= 32'(IMEM_DEPTH);
        bad          = misaligned | out_of_range;
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, sequences the BRAM and pairs each
// returned word with its PC and a valid flag for decode.
module imem_fetch_ctrl
    import imem_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      halt,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    imem_fetch_ctrl_if.master         bram,
    output logic [31:0]               instr_out,
    output logic [31:0]               instr_pc,
    output logic                      instr_valid,
    output logic                      halted,
    output logic                      fault
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fault_q, fault_d;
    logic        pc_bad;
    logic        redir_bad;

    pc_range_check u_pc_chk    (.pc(pc_q),        .bad(pc_bad));
    pc_range_check u_redir_chk (.pc(redirect_pc), .bad(redir_bad));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    // Redirect is accepted in every state, so it is resolved ahead of the
    // per-state decisions; a bad target parks the controller in HALTED.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;
        if (redirect_valid) begin
            instr_valid_d = 1'b0;
            if (redir_bad) begin
                fault_d = 1'b1;
                state_d = HALTED;
            end else begin
                pc_d    = redirect_pc;
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                BOOT: begin
                    instr_valid_d = 1'b0;
                    state_d       = halt ? HALTED : FETCH;
                end
                FETCH: begin
                    if (halt) begin
                        instr_valid_d = 1'b0;
                        state_d       = HALTED;
                    end else if (!stall) begin
                        if (pc_bad) begin
                            instr_valid_d = 1'b0;
                            fault_d       = 1'b1;
                            state_d       = HALTED;
                        end else begin
                            instr_valid_d = 1'b1;
                            instr_pc_d    = pc_q;
                            pc_d          = pc_q + PC_INC;
                        end
                    end
                end
                HALTED: instr_valid_d = 1'b0;
                default: begin
                    instr_valid_d = 1'b0;
                    state_d       = BOOT;
                end
            endcase
        end
    end

    always_comb begin
        bram.imem_ena  = (state_q == FETCH) && !redirect_valid && !halt && !stall && !pc_bad;
        bram.imem_addr = pc_q >> ADDR_SHIFT;
        instr_out      = bram.imem_instr;
        instr_pc       = instr_pc_q;
        instr_valid    = instr_valid_q;
        halted         = (state_q == HALTED);
        fault          = fault_q;
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed walk through the fetch scenarios, then
// random traffic, all compared every cycle against a behavioural model.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        halted;
    logic        fault;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bram           (bus),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .halted         (halted),
        .fault          (fault)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // BRAM stand-in: douta updates only on an enabled read, otherwise holds.
    always @(posedge clk) begin
        if (bus.imem_ena === 1'b1) bus.imem_instr <= word_at(bus.imem_addr);
    end

    int checks = 0;
    int failures = 0;

    // Behavioural model: mode 0 = booting, 1 = running, 2 = halted.
    bit          m_known = 1'b0;
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    bit          m_valid;
    bit          m_fault;

    function automatic bit m_bad(input logic [31:0] p);
        return (p % 4 != 0) || (p / 4 >= 1024);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit exp_ena;
        if (!m_known) return;
        exp_ena = (m_mode == 1) && !redirect_valid && !halt && !stall && !m_bad(m_pc);
        chk("imem_addr",   bus.imem_addr,       m_pc / 4);
        chk("imem_ena",    32'(bus.imem_ena),   32'(exp_ena));
        chk("instr_valid", 32'(instr_valid),    32'(m_valid));
        chk("instr_pc",    instr_pc,            m_ipc);
        chk("halted",      32'(halted),         32'(m_mode == 2));
        chk("fault",       32'(fault),          32'(m_fault));
        if (m_valid) chk("instr_out", instr_out, word_at(m_ipc / 4));
    endtask

    task automatic model_step();
        if (rst) begin
            m_known = 1'b1;
            m_mode  = 0;
            m_pc    = 32'h0;
            m_ipc   = 32'h0;
            m_valid = 1'b0;
            m_fault = 1'b0;
            return;
        end
        if (!m_known) return;
        if (redirect_valid) begin
            m_valid = 1'b0;
            if (m_bad(redirect_pc)) begin
                m_fault = 1'b1;
                m_mode  = 2;
            end else begin
                m_pc   = redirect_pc;
                m_mode = 1;
            end
        end else if (m_mode == 0) begin
            m_mode = halt ? 2 : 1;
        end else if (m_mode == 2) begin
            m_valid = 1'b0;
        end else if (halt) begin
            m_mode  = 2;
            m_valid = 1'b0;
        end else if (!stall) begin
            if (m_bad(m_pc)) begin
                m_fault = 1'b1;
                m_mode  = 2;
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_ipc   = m_pc;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    // Apply inputs for one cycle, compare the outputs of that cycle, advance the model.
    task automatic cycle(input bit r, input bit s, input bit h, input bit rv, input logic [31:0] rpc);
        @(negedge clk);
        rst            = r;
        stall          = s;
        halt           = h;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        compare_all();
        model_step();
    endtask

    initial begin
        // Reset, then free-run from RESET_PC.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_boot_ena", 32'(bus.imem_ena), 32'h0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_addr0", bus.imem_addr, 32'h0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_addr1", bus.imem_addr, 32'h1);
        chk("lit_pc0", instr_pc, 32'h0);
        chk("lit_valid0", 32'(instr_valid), 32'h1);
        cycle(0, 0, 0, 0, 0);
        chk("lit_pc4", instr_pc, 32'h4);

        // Stall three cycles while 0x8 is presented.
        cycle(0, 1, 0, 0, 0);
        chk("lit_pc8", instr_pc, 32'h8);
        chk("lit_word2", instr_out, word_at(32'd2));
        chk("lit_stall_ena", 32'(bus.imem_ena), 32'h0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        chk("lit_stall_hold", instr_pc, 32'h8);
        cycle(0, 0, 0, 0, 0);
        chk("lit_release_pc", instr_pc, 32'h8);
        cycle(0, 0, 0, 0, 0);
        chk("lit_pcC", instr_pc, 32'hC);

        // Redirect to 0x40, then again with stall asserted at R.
        cycle(0, 0, 0, 1, 32'h40);
        chk("lit_redir_ena", 32'(bus.imem_ena), 32'h0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_bubble", 32'(instr_valid), 32'h0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_pc40", instr_pc, 32'h40);
        chk("lit_valid40", 32'(instr_valid), 32'h1);
        cycle(0, 0, 0, 0, 0);
        chk("lit_pc44", instr_pc, 32'h44);
        cycle(0, 1, 0, 1, 32'h80);
        cycle(0, 0, 0, 0, 0);
        chk("lit_bubble_stall", 32'(instr_valid), 32'h0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_pc80", instr_pc, 32'h80);
        cycle(0, 0, 0, 0, 0);
        chk("lit_pc84", instr_pc, 32'h84);

        // Halt for one cycle, stay halted, resume via redirect.
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_halted", 32'(halted), 32'h1);
        chk("lit_halt_valid", 32'(instr_valid), 32'h0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_halted_persist", 32'(halted), 32'h1);
        cycle(0, 0, 0, 1, 32'h100);
        cycle(0, 0, 0, 0, 0);
        chk("lit_unhalted", 32'(halted), 32'h0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_pc100", instr_pc, 32'h100);
        chk("lit_valid100", 32'(instr_valid), 32'h1);

        // Misaligned redirect faults; a legal redirect still leaves HALTED.
        cycle(0, 0, 0, 1, 32'h42);
        chk("lit_fault_ena", 32'(bus.imem_ena), 32'h0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_fault", 32'(fault), 32'h1);
        chk("lit_fault_halted", 32'(halted), 32'h1);
        cycle(0, 0, 0, 1, 32'h200);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_pc200", instr_pc, 32'h200);
        chk("lit_fault_sticky", 32'(fault), 32'h1);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_fault_cleared", 32'(fault), 32'h0);

        // Run off the end of memory.
        cycle(0, 0, 0, 1, 32'hFF0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_last_pc", instr_pc, 32'hFFC);
        chk("lit_end_ena", 32'(bus.imem_ena), 32'h0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_end_fault", 32'(fault), 32'h1);

        // Reset in R+1 of a redirect.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h300);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_rst_mid_valid", 32'(instr_valid), 32'h0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_rst_mid_addr", bus.imem_addr, 32'h0);
        cycle(0, 0, 0, 0, 0);
        chk("lit_rst_mid_pc", instr_pc, 32'h0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit          r, s, h, rv;
            logic [31:0] rpc;
            int unsigned sel;
            r   = ($urandom % 96) == 0;
            s   = ($urandom % 5) == 0;
            h   = ($urandom % 40) == 0;
            rv  = ($urandom % 12) == 0;
            sel = $urandom % 10;
            if (sel < 7)       rpc = 32'($urandom_range(0, 1023)) * 32'd4;
            else if (sel == 7) rpc = (32'($urandom_range(0, 1023)) * 32'd4) | 32'($urandom_range(1, 3));
            else if (sel == 8) rpc = 32'h1000 + 32'($urandom_range(0, 4095)) * 32'd4;
            else               rpc = 32'($urandom_range(1018, 1023)) * 32'd4;
            cycle(r, s, h, rv, rpc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequences the synchronous-read instruction BRAM: owns the program counter and drives its address and enable.
- Realigns the BRAM's 1-cycle read latency so each instruction word leaves paired with its PC and a valid flag.
- Supports stall, branch/jump redirect, halt, and address/alignment faults.
- Sits between the instruction memory and the decode stage of the KGP-RISC core.

Parameters:
- RESET_PC, 32'h0000_0000: byte address of the first fetch after reset.
- PC_INC, 4: byte increment per sequential fetch.
- ADDR_SHIFT, 2: right shift from byte PC to BRAM word address.
- IMEM_DEPTH, 1024: BRAM depth in words. Word index >= IMEM_DEPTH is a fault.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  downstream cannot accept. Hold the current instruction.
- halt  in  1  stop fetching; enter HALTED.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  32  byte target of the redirect.
- imem_addr  out  32  word address to BRAM: zero-extended pc_q >> ADDR_SHIFT.
- imem_ena  out  1  BRAM read enable.
- imem_instr  in  32  BRAM douta; valid 1 cycle after an enabled read.
- instr_out  out  32  instruction to decode. Passthrough of imem_instr.
- instr_pc  out  32  byte PC of instr_out.
- instr_valid  out  1  instr_out/instr_pc are a live instruction.
- halted  out  1  controller is in HALTED.
- fault  out  1  sticky: out-of-range or misaligned PC detected.

Behaviour:
- Reset and clocking: one clock; reset is synchronous and active-high (clk, rst). While rst=1 at an edge, the next-cycle values are:
  - pc_q=RESET_PC, state=BOOT
  - imem_ena=0, instr_valid=0, instr_pc=0
  - halted=0, fault=0
- rst overrides every other input, including mid-redirect, mid-stall and HALTED.
- States: BOOT, FETCH, HALTED.
- BOOT:
  - lasts one cycle, imem_ena=0, then goes to FETCH.
  - halt in BOOT goes to HALTED.
  - redirect in BOOT loads pc_q and goes to FETCH.
- FETCH input priority: redirect > halt > stall > sequential.
  - Sequential (no redirect/halt/stall): imem_ena=1. Next cycle: instr_valid=1, instr_pc=pc_q of this cycle. pc_q += PC_INC.
  - Fetch latency: address issued at cycle N, instruction valid at N+1.
  - pc_q wraps modulo 2^32, but the range check below faults before any wrap within a real memory.
  - Stall: imem_ena=0, so BRAM douta and instr_out hold. pc_q, instr_pc and instr_valid hold. Unbounded stall duration is legal.
  - Redirect at cycle R:
    - imem_ena=0 in R; pc_q<=redirect_pc.
    - R+1: instr_valid=0 (squash bubble); target is issued.
    - R+2: instr_valid=1, instr_pc=redirect_pc.
    - Redirect during stall is accepted; the held instruction is dropped.
  - Halt: imem_ena=0. Next cycle state=HALTED, instr_valid=0, halted=1.
- HALTED:
  - imem_ena=0, instr_valid=0, halted=1.
  - Stall and halt are ignored.
  - redirect_valid exits to FETCH with the same R/R+1/R+2 timing; halted=0 from R+1.
- Fault check: evaluated on every pc_q about to be issued (imem_ena would be 1), and on every accepted redirect_pc.
  - Condition: low ADDR_SHIFT bits nonzero, or (pc>>ADDR_SHIFT) >= IMEM_DEPTH.
  - On fault: suppress the read (imem_ena=0); next cycle fault=1, state=HALTED, instr_valid=0.
  - fault clears only on rst. Redirect out of HALTED is still honoured if the target is legal.
- No combinational path from redirect_pc or stall to imem_addr; imem_addr is driven from pc_q only. imem_ena is combinational from state, stall, halt and redirect_valid.

Decomposition:
- Package imem_pkg holds:
  - the state encoding (BOOT=2'd0, FETCH=2'd1, HALTED=2'd2)
  - the constants RESET_PC, PC_INC, ADDR_SHIFT, IMEM_DEPTH, shared with the instruction-memory wrapper.
- One sub-module, pc_range_check: combinational misalign/out-of-range test on a 32-bit byte PC.
- The controller instantiates no memory; it connects to the existing instruction memory wrapper at top level.

Test Plan:
- Reset then free-run: rst for 2 cycles, then release. Expect:
  - imem_addr 0,1,2,3; instr_pc 0x0,0x4,0x8 with instr_valid=1 starting 2 cycles after rst release.
  - instr_out equals the preloaded words at those addresses.
- Stall: assert stall for 3 cycles while instr_pc=0x8. Expect:
  - instr_pc=0x8 and instr_out constant, imem_ena=0.
  - After release, instr_pc=0xC the next cycle.
- Redirect: redirect_valid=1 with redirect_pc=0x40 at cycle R. Expect:
  - instr_valid=0 at R+1.
  - instr_pc=0x40, valid=1 at R+2, then 0x44.
  - Repeat with stall=1 at R: same timing.
- Halt/resume:
  - halt=1 for one cycle: halted=1 and valid=0 persist with halt low.
  - Then redirect_pc=0x100: valid at +2 with instr_pc=0x100, halted=0.
- Faults:
  - redirect_pc=0x42 gives fault=1, halted=1, no BRAM read.
  - Separately, run sequentially to address (IMEM_DEPTH-1)*4: the next issue faults and the last valid instr_pc is 0xFFC (depth 1024).
  - rst clears fault.
- Reset mid-redirect: rst asserted in cycle R+1 of a redirect. Expect restart from RESET_PC with no valid output for the redirect target.
